// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase controller: phase states,
// lamp patterns, default phase durations and lamp decode helpers.
package traffic_pkg;

    // Phase encoding; 3'd7 is unused and is steered to AR2.
    typedef enum logic [2:0] {
        MG   = 3'd0,
        MY   = 3'd1,
        AR1  = 3'd2,
        WALK = 3'd3,
        SG   = 3'd4,
        SY   = 3'd5,
        AR2  = 3'd6
    } phase_e;

    // Lamp patterns, {red, yellow, green}, one-hot.
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Default durations in timer ticks (legal range 1..15).
    localparam logic [3:0] D_MAIN = 4'd6;
    localparam logic [3:0] D_SIDE = 4'd4;
    localparam logic [3:0] D_EXT  = 4'd3;
    localparam logic [3:0] D_YEL  = 4'd2;
    localparam logic [3:0] D_RED  = 4'd1;
    localparam logic [3:0] D_WALK = 4'd5;

    // Main-road lamp for a phase; anything that is not MG/MY shows red.
    function automatic logic [2:0] main_lamp_of(input phase_e ph);
        case (ph)
            MG:      main_lamp_of = LAMP_G;
            MY:      main_lamp_of = LAMP_Y;
            default: main_lamp_of = LAMP_R;
        endcase
    endfunction

    // Side-road lamp for a phase; anything that is not SG/SY shows red.
    function automatic logic [2:0] side_lamp_of(input phase_e ph);
        case (ph)
            SG:      side_lamp_of = LAMP_G;
            SY:      side_lamp_of = LAMP_Y;
            default: side_lamp_of = LAMP_R;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_controller_req_latch.sv
// Set/clear request flop. Clear beats set when both arrive together, so a
// request coinciding with its own service is dropped for that one cycle.
module req_latch (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_set,
    input  logic i_clr,
    output logic o_q
);

    logic r_q;

    // Clear-priority set/reset register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_q <= 1'b0;
        else if (i_clr) r_q <= 1'b0;
        else if (i_set) r_q <= 1'b1;
    end

    assign o_q = r_q;

endmodule

// File: rtl/traffic_phase_controller.sv
// Intersection phase sequencer. Chooses the next phase on each accepted
// timer expiry, loads the external countdown timer with that phase's
// duration and drives the lamp outputs, all from registers.
//
// Timer handshake: start_timer is a one-cycle pulse; timer_value is valid
// in that cycle. expired is accepted only when start_timer was low in the
// current and the previous cycle (the timer's reload window is ignored).
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter logic [3:0] T_MAIN = D_MAIN,
    parameter logic [3:0] T_SIDE = D_SIDE,
    parameter logic [3:0] T_EXT  = D_EXT,
    parameter logic [3:0] T_YEL  = D_YEL,
    parameter logic [3:0] T_RED  = D_RED,
    parameter logic [3:0] T_WALK = D_WALK
) (
    input  logic       clk,
    input  logic       sys_reset,
    input  logic       sensor,
    input  logic       walk_btn,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] timer_value,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       walk_lamp,
    output logic [2:0] phase
);

    // A zero duration would make the timer wrap through 16 ticks.
    if (T_MAIN == 4'd0 || T_SIDE == 4'd0 || T_EXT == 4'd0 ||
        T_YEL == 4'd0 || T_RED == 4'd0 || T_WALK == 4'd0) begin : g_bad_duration
        $error("traffic_phase_controller: every duration must be 1..15");
    end

    phase_e     r_state;
    logic       r_init;
    logic       r_start;
    logic       r_start_d;
    logic [3:0] r_tval;
    logic [2:0] r_main;
    logic [2:0] r_side;
    logic       r_walk;
    logic       r_ext_used;

    phase_e     w_next;
    logic       w_enter;
    logic       w_ext_take;
    logic [3:0] w_dur;
    logic       w_exp_ok;
    logic       w_side_req;
    logic       w_walk_req;
    logic       w_side_set;
    logic       w_walk_set;

    assign w_exp_ok = expired & ~r_start & ~r_start_d;

    // Side requests are collected everywhere except SG/SY; served on SG entry.
    assign w_side_set = sensor & (r_state != SG) & (r_state != SY);
    // Walk requests are collected everywhere except WALK; served on WALK entry.
    assign w_walk_set = walk_btn & (r_state != WALK);

    req_latch u_side_req (
        .i_clk   (clk),
        .i_rst_n (sys_reset),
        .i_set   (w_side_set),
        .i_clr   (w_enter && w_next == SG),
        .o_q     (w_side_req)
    );

    req_latch u_walk_req (
        .i_clk   (clk),
        .i_rst_n (sys_reset),
        .i_set   (w_walk_set),
        .i_clr   (w_enter && w_next == WALK),
        .o_q     (w_walk_req)
    );

    // Next phase, entry strobe and the duration to load on entry.
    always_comb begin
        w_next     = r_state;
        w_enter    = 1'b0;
        w_ext_take = 1'b0;
        if (r_init) begin
            w_next  = MG;
            w_enter = 1'b1;
        end else begin
            case (r_state)
                MG: if (w_exp_ok) begin
                    w_enter = 1'b1;
                    w_next  = (w_side_req || w_walk_req) ? MY : MG;
                end
                MY: if (w_exp_ok) begin
                    w_enter = 1'b1;
                    w_next  = AR1;
                end
                AR1: if (w_exp_ok) begin
                    w_enter = 1'b1;
                    w_next  = w_walk_req ? WALK : (w_side_req ? SG : AR2);
                end
                WALK: if (w_exp_ok) begin
                    w_enter = 1'b1;
                    w_next  = w_side_req ? SG : AR2;
                end
                SG: if (w_exp_ok) begin
                    w_enter = 1'b1;
                    if (sensor && !r_ext_used) begin
                        w_next     = SG;
                        w_ext_take = 1'b1;
                    end else begin
                        w_next = SY;
                    end
                end
                SY: if (w_exp_ok) begin
                    w_enter = 1'b1;
                    w_next  = AR2;
                end
                AR2: if (w_exp_ok) begin
                    w_enter = 1'b1;
                    w_next  = MG;
                end
                default: begin
                    w_enter = ~r_start;
                    w_next  = AR2;
                end
            endcase
        end

        case (w_next)
            MG:      w_dur = T_MAIN;
            MY:      w_dur = T_YEL;
            AR1:     w_dur = T_RED;
            WALK:    w_dur = T_WALK;
            SG:      w_dur = w_ext_take ? T_EXT : T_SIDE;
            SY:      w_dur = T_YEL;
            default: w_dur = T_RED;
        endcase
    end

    // State, timer load and lamp registers; reset shows MG lamps at once.
    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            r_state    <= MG;
            r_init     <= 1'b1;
            r_start    <= 1'b0;
            r_start_d  <= 1'b0;
            r_tval     <= T_MAIN;
            r_main     <= LAMP_G;
            r_side     <= LAMP_R;
            r_walk     <= 1'b0;
            r_ext_used <= 1'b0;
        end else begin
            r_init    <= 1'b0;
            r_start   <= w_enter;
            r_start_d <= r_start;
            if (w_enter) begin
                r_state <= w_next;
                r_tval  <= w_dur;
                r_main  <= main_lamp_of(w_next);
                r_side  <= side_lamp_of(w_next);
                r_walk  <= (w_next == WALK);
            end
            if (w_ext_take)
                r_ext_used <= 1'b1;
            else if (w_enter && w_next == SY)
                r_ext_used <= 1'b0;
        end
    end

    assign start_timer = r_start;
    assign timer_value = r_tval;
    assign main_lamp   = r_main;
    assign side_lamp   = r_side;
    assign walk_lamp   = r_walk;
    assign phase       = r_state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with a random safety run.
module tb_traffic_phase_controller;
    import traffic_pkg::*;

    typedef struct {
        logic [2:0] ph;
        logic [3:0] tv;
        logic [2:0] ml;
        logic [2:0] sl;
        logic       wl;
    } step_t;

    logic       clk = 1'b0;
    logic       sys_reset;
    logic       sensor;
    logic       walk_btn;
    logic       expired;
    logic       start_timer;
    logic [3:0] timer_value;
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic       walk_lamp;
    logic [2:0] phase;

    int n_cmp = 0;
    int n_bad = 0;

    traffic_phase_controller dut (
        .clk         (clk),
        .sys_reset   (sys_reset),
        .sensor      (sensor),
        .walk_btn    (walk_btn),
        .expired     (expired),
        .start_timer (start_timer),
        .timer_value (timer_value),
        .main_lamp   (main_lamp),
        .side_lamp   (side_lamp),
        .walk_lamp   (walk_lamp),
        .phase       (phase)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Driver tasks: everything is driven and sampled 1ns after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Let the reload window pass, then give one expired pulse.
    task automatic do_expire();
        idle(3);
        expired = 1'b1;
        step();
        expired = 1'b0;
    endtask

    task automatic test_reset();
        sys_reset = 1'b0;
        sensor    = 1'b0;
        walk_btn  = 1'b0;
        expired   = 1'b0;
        idle(2);
        n_cmp++; if (start_timer !== 1'b0) begin n_bad++; $display("FAIL reset_start got %b want 0", start_timer); end
        n_cmp++; if (timer_value !== 4'd6) begin n_bad++; $display("FAIL reset_tval got %0d want 6", timer_value); end
        n_cmp++; if (main_lamp !== 3'b001) begin n_bad++; $display("FAIL reset_main got %b want 001", main_lamp); end
        n_cmp++; if (side_lamp !== 3'b100) begin n_bad++; $display("FAIL reset_side got %b want 100", side_lamp); end
        n_cmp++; if (walk_lamp !== 1'b0)   begin n_bad++; $display("FAIL reset_walk got %b want 0", walk_lamp); end
        n_cmp++; if (phase !== 3'd0)       begin n_bad++; $display("FAIL reset_phase got %0d want 0", phase); end
        sys_reset = 1'b1;
        step();
        n_cmp++; if (start_timer !== 1'b1) begin n_bad++; $display("FAIL release_start got %b want 1", start_timer); end
        n_cmp++; if (timer_value !== 4'd6) begin n_bad++; $display("FAIL release_tval got %0d want 6", timer_value); end
        step();
        n_cmp++; if (start_timer !== 1'b0) begin n_bad++; $display("FAIL release_pulse_width got %b want 0", start_timer); end
    endtask

    task automatic test_no_requests();
        for (int i = 0; i < 3; i++) begin
            do_expire();
            n_cmp++; if (start_timer !== 1'b1) begin n_bad++; $display("FAIL idle_start[%0d] got %b want 1", i, start_timer); end
            n_cmp++; if (timer_value !== 4'd6) begin n_bad++; $display("FAIL idle_tval[%0d] got %0d want 6", i, timer_value); end
            n_cmp++; if (main_lamp !== 3'b001) begin n_bad++; $display("FAIL idle_main[%0d] got %b want 001", i, main_lamp); end
            n_cmp++; if (phase !== 3'd0)       begin n_bad++; $display("FAIL idle_phase[%0d] got %0d want 0", i, phase); end
        end
    endtask

    task automatic test_side_cycle();
        step_t seq [7];
        seq = '{'{3'd1, 4'd2, 3'b010, 3'b100, 1'b0},
                '{3'd2, 4'd1, 3'b100, 3'b100, 1'b0},
                '{3'd4, 4'd4, 3'b100, 3'b001, 1'b0},
                '{3'd5, 4'd2, 3'b100, 3'b010, 1'b0},
                '{3'd6, 4'd1, 3'b100, 3'b100, 1'b0},
                '{3'd0, 4'd6, 3'b001, 3'b100, 1'b0},
                '{3'd0, 4'd6, 3'b001, 3'b100, 1'b0}};
        sensor = 1'b1;
        step();
        sensor = 1'b0;
        for (int i = 0; i < 7; i++) begin
            do_expire();
            n_cmp++; if (phase !== seq[i].ph)       begin n_bad++; $display("FAIL side_phase[%0d] got %0d want %0d", i, phase, seq[i].ph); end
            n_cmp++; if (start_timer !== 1'b1)      begin n_bad++; $display("FAIL side_start[%0d] got %b want 1", i, start_timer); end
            n_cmp++; if (timer_value !== seq[i].tv) begin n_bad++; $display("FAIL side_tval[%0d] got %0d want %0d", i, timer_value, seq[i].tv); end
            n_cmp++; if (main_lamp !== seq[i].ml)   begin n_bad++; $display("FAIL side_main[%0d] got %b want %b", i, main_lamp, seq[i].ml); end
            n_cmp++; if (side_lamp !== seq[i].sl)   begin n_bad++; $display("FAIL side_side[%0d] got %b want %b", i, side_lamp, seq[i].sl); end
        end
    endtask

    task automatic test_extension();
        step_t seq [7];
        seq = '{'{3'd1, 4'd2, 3'b010, 3'b100, 1'b0},
                '{3'd2, 4'd1, 3'b100, 3'b100, 1'b0},
                '{3'd4, 4'd4, 3'b100, 3'b001, 1'b0},
                '{3'd4, 4'd3, 3'b100, 3'b001, 1'b0},
                '{3'd5, 4'd2, 3'b100, 3'b010, 1'b0},
                '{3'd6, 4'd1, 3'b100, 3'b100, 1'b0},
                '{3'd0, 4'd6, 3'b001, 3'b100, 1'b0}};
        sensor = 1'b1;
        for (int i = 0; i < 7; i++) begin
            do_expire();
            // Sensor stays high through both SG expiries, then drops in SY.
            if (i == 4) sensor = 1'b0;
            n_cmp++; if (phase !== seq[i].ph)       begin n_bad++; $display("FAIL ext_phase[%0d] got %0d want %0d", i, phase, seq[i].ph); end
            n_cmp++; if (start_timer !== 1'b1)      begin n_bad++; $display("FAIL ext_start[%0d] got %b want 1", i, start_timer); end
            n_cmp++; if (timer_value !== seq[i].tv) begin n_bad++; $display("FAIL ext_tval[%0d] got %0d want %0d", i, timer_value, seq[i].tv); end
            n_cmp++; if (side_lamp !== seq[i].sl)   begin n_bad++; $display("FAIL ext_side[%0d] got %b want %b", i, side_lamp, seq[i].sl); end
        end
    endtask

    task automatic test_walk();
        step_t seq [8];
        seq = '{'{3'd1, 4'd2, 3'b010, 3'b100, 1'b0},
                '{3'd2, 4'd1, 3'b100, 3'b100, 1'b0},
                '{3'd3, 4'd5, 3'b100, 3'b100, 1'b1},
                '{3'd4, 4'd4, 3'b100, 3'b001, 1'b0},
                '{3'd5, 4'd2, 3'b100, 3'b010, 1'b0},
                '{3'd6, 4'd1, 3'b100, 3'b100, 1'b0},
                '{3'd0, 4'd6, 3'b001, 3'b100, 1'b0},
                '{3'd0, 4'd6, 3'b001, 3'b100, 1'b0}};
        sensor   = 1'b1;
        walk_btn = 1'b1;
        step();
        sensor   = 1'b0;
        walk_btn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_expire();
            n_cmp++; if (phase !== seq[i].ph)       begin n_bad++; $display("FAIL walk_phase[%0d] got %0d want %0d", i, phase, seq[i].ph); end
            n_cmp++; if (timer_value !== seq[i].tv) begin n_bad++; $display("FAIL walk_tval[%0d] got %0d want %0d", i, timer_value, seq[i].tv); end
            n_cmp++; if (main_lamp !== seq[i].ml)   begin n_bad++; $display("FAIL walk_main[%0d] got %b want %b", i, main_lamp, seq[i].ml); end
            n_cmp++; if (side_lamp !== seq[i].sl)   begin n_bad++; $display("FAIL walk_side[%0d] got %b want %b", i, side_lamp, seq[i].sl); end
            n_cmp++; if (walk_lamp !== seq[i].wl)   begin n_bad++; $display("FAIL walk_lamp[%0d] got %b want %b", i, walk_lamp, seq[i].wl); end
        end
    endtask

    task automatic test_reset_mid_phase();
        sensor = 1'b1;
        step();
        sensor = 1'b0;
        for (int i = 0; i < 3; i++) do_expire();
        n_cmp++; if (phase !== 3'd4) begin n_bad++; $display("FAIL mid_setup_phase got %0d want 4", phase); end
        idle(1);
        sys_reset = 1'b0;
        #1;
        n_cmp++; if (main_lamp !== 3'b001) begin n_bad++; $display("FAIL mid_async_main got %b want 001", main_lamp); end
        n_cmp++; if (side_lamp !== 3'b100) begin n_bad++; $display("FAIL mid_async_side got %b want 100", side_lamp); end
        n_cmp++; if (phase !== 3'd0)       begin n_bad++; $display("FAIL mid_async_phase got %0d want 0", phase); end
        expired = 1'b1;
        step();
        sys_reset = 1'b1;
        step();
        n_cmp++; if (start_timer !== 1'b1) begin n_bad++; $display("FAIL mid_release_start got %b want 1", start_timer); end
        n_cmp++; if (timer_value !== 4'd6) begin n_bad++; $display("FAIL mid_release_tval got %0d want 6", timer_value); end
        step();
        n_cmp++; if (start_timer !== 1'b0) begin n_bad++; $display("FAIL mid_stale1_start got %b want 0", start_timer); end
        n_cmp++; if (phase !== 3'd0)       begin n_bad++; $display("FAIL mid_stale1_phase got %0d want 0", phase); end
        step();
        expired = 1'b0;
        n_cmp++; if (start_timer !== 1'b0) begin n_bad++; $display("FAIL mid_stale2_start got %b want 0", start_timer); end
        n_cmp++; if (phase !== 3'd0)       begin n_bad++; $display("FAIL mid_stale2_phase got %0d want 0", phase); end
    endtask

    task automatic test_random_safety();
        logic prev_start;
        prev_start = start_timer;
        for (int i = 0; i < 10000; i++) begin
            sensor   = ($urandom_range(0, 3) == 0);
            walk_btn = ($urandom_range(0, 7) == 0);
            expired  = ($urandom_range(0, 2) == 0);
            step();
            n_cmp++;
            if (main_lamp !== LAMP_R && side_lamp !== LAMP_R) begin
                n_bad++;
                $display("FAIL rand_conflict[%0d] main %b side %b, one must be 100", i, main_lamp, side_lamp);
            end
            n_cmp++;
            if (prev_start === 1'b1 && start_timer !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_start_back_to_back[%0d] got %b want 0", i, start_timer);
            end
            prev_start = start_timer;
        end
        sensor   = 1'b0;
        walk_btn = 1'b0;
        expired  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_no_requests();
        test_side_cycle();
        test_extension();
        test_walk();
        test_reset_mid_phase();
        test_random_safety();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
